// File: rtl/memory_flash_line_reader.sv
// Single-line read buffer in front of an Avalon-MM burst flash.
// A host word read hits the buffered line (1-cycle ack), misses and refills the
// whole line with one burst, or falls outside flash and returns zero.
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_request, i_address        host read request and word address
//   o_busy, o_ack, o_data       not-accepting flag, data strobe, read data
//   i_invalidate                drop the buffered line
//   o_flash_*/i_flash_*         Avalon-MM burst read master
module memory_flash_line_reader #(
  parameter int unsigned           ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] FLASH_END  = 19'h059FF,
  parameter int unsigned           LINE_WORDS = 4,
  parameter bit                    BYTE_SWAP  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_request,
  output logic                  o_busy,
  output logic                  o_ack,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [31:0]           o_data,
  input  logic                  i_invalidate,
  output logic [ADDR_WIDTH-1:0] o_flash_address,
  output logic                  o_flash_read,
  output logic [3:0]            o_flash_burstcount,
  input  logic                  i_flash_waitrequest,
  input  logic                  i_flash_readdatavalid,
  input  logic [31:0]           i_flash_readdata
);

  localparam int unsigned           IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FILL, RESPOND} state_t;

  state_t                  state, state_next;
  logic [31:0]             line_buf [LINE_WORDS];
  logic [ADDR_WIDTH-1:0]   tag_q;      // line base address of buffered data
  logic                    valid;
  logic                    inv_pend;   // invalidate seen while a miss is in flight
  logic [IDX_W-1:0]        beat_cnt;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    hit_c;
  logic                    last_beat_c;
  logic                    ack_c;
  logic [31:0]             data_c;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a & OFF_MASK);
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] d);
    return BYTE_SWAP ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

  // An invalidate arriving with the request forces a miss.
  assign hit_c       = valid && !i_invalidate && ((i_address & ~OFF_MASK) == tag_q);
  assign last_beat_c = i_flash_readdatavalid && (beat_cnt == LAST_BEAT);

  assign o_flash_burstcount = 4'(LINE_WORDS);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and the ack/data to register for the following cycle
  always_comb begin
    state_next = state;
    ack_c      = 1'b0;
    data_c     = '0;
    case (state)
      IDLE: begin
        if (i_request) begin
          if (i_address > FLASH_END) begin
            ack_c = 1'b1;
          end else if (hit_c) begin
            ack_c  = 1'b1;
            data_c = swap(line_buf[word_idx(i_address)]);
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!i_flash_waitrequest) state_next = FILL;
      end
      FILL: begin
        if (last_beat_c) begin
          state_next = RESPOND;
          ack_c      = 1'b1;
          // The final beat is not in the buffer yet; forward it.
          data_c     = swap((word_idx(req_addr) == LAST_BEAT) ? i_flash_readdata
                                                               : line_buf[word_idx(req_addr)]);
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control, tag and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid           <= 1'b0;
      inv_pend        <= 1'b0;
      beat_cnt        <= '0;
      tag_q           <= '0;
      req_addr        <= '0;
      o_ack           <= 1'b0;
      o_data          <= '0;
      o_busy          <= 1'b0;
      o_flash_read    <= 1'b0;
      o_flash_address <= '0;
    end else begin
      o_ack        <= ack_c;
      o_busy       <= (state_next != IDLE);
      o_flash_read <= (state_next == ISSUE);
      if (ack_c) o_data <= data_c;

      if (state == IDLE) begin
        if (i_invalidate) valid <= 1'b0;
        if (i_request) req_addr <= i_address;
        if (state_next == ISSUE) begin
          valid           <= 1'b0;
          inv_pend        <= 1'b0;
          o_flash_address <= i_address & ~OFF_MASK;
        end
      end else if (i_invalidate) begin
        inv_pend <= 1'b1;
      end

      if (state == FILL && i_flash_readdatavalid) begin
        if (last_beat_c) begin
          beat_cnt <= '0;
          tag_q    <= req_addr & ~OFF_MASK;
          valid    <= !(inv_pend || i_invalidate);
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      if (state == RESPOND && i_invalidate) valid <= 1'b0;
    end
  end

  // Line storage
  always_ff @(posedge i_clk) begin
    if (state == FILL && i_flash_readdatavalid) line_buf[beat_cnt] <= i_flash_readdata;
  end

endmodule
